golden_nonce_queue: RTL and testbench

Buffers golden nonces reported by the hashing cores and serialises them, one 32-bit word at a time, into the `serial_transmit` stage using its `send`/`word`/`busy` handshake. It sits directly upstream of `serial_transmit`, between the hasher array and the UART TX path. Nonces that arrive while a word is still being shifted out are queued rather than lost. The queue is flushed when new work arrives from `serial_receive` (`rx_done`).

---
 rtl/miner_pkg.sv | 13 +
 rtl/nonce_fifo.sv | 54 +++++
 rtl/golden_nonce_queue.sv | 104 ++++++++++
 tb/tb_golden_nonce_queue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the nonce reporting path: word width and the TX
// handshake state encoding.
package miner_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Register-array FIFO with first-word-fall-through output. The pointers carry
// one extra wrap bit so that full and empty can be told apart.
module nonce_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO only lands when a pop frees the slot this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/golden_nonce_queue.sv
// Queues golden nonces from the hasher array and hands them one at a time to
// serial_transmit over its send/word/busy handshake.
module golden_nonce_queue
   import miner_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DEDUP = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NONCE_W-1:0]       nonce_in,
   input  logic                     nonce_valid,
   input  logic                     new_work,
   input  logic                     tx_busy,
   output logic                     tx_send,
   output logic [NONCE_W-1:0]       tx_word,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     overflow
);

   tx_state_t          state;
   tx_state_t          state_next;
   logic [NONCE_W-1:0] last_nonce;
   logic               last_valid;
   logic [NONCE_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               is_dup;
   logic               pop;
   logic               push;
   logic               drop;

   assign is_dup = (DEDUP != 0) && last_valid && (nonce_in == last_nonce);
   assign push   = nonce_valid && !new_work && !is_dup && (!fifo_full || pop);
   assign drop   = nonce_valid && !new_work && !is_dup && fifo_full && !pop;

   nonce_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (new_work),
      .din     (nonce_in),
      .dout    (fifo_dout),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign empty = fifo_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // busy is only trusted once seen high in SEND; the transmitter never resets it.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (!fifo_empty && !new_work) state_next = ST_SEND;
         ST_SEND: if (tx_busy)                  state_next = ST_WAIT;
         ST_WAIT: if (!tx_busy)                 state_next = ST_IDLE;
         default:                               state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      tx_send = 1'b0;
      case (state)
         ST_IDLE: pop     = !fifo_empty && !new_work;
         ST_SEND: tx_send = 1'b1;
         default: ;
      endcase
   end

   // tx_word only changes on a pop, so it stays put through SEND and WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_word    <= '0;
         last_nonce <= '0;
         last_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (pop) tx_word <= fifo_dout;
         if (new_work) begin
            last_valid <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            if (push) begin
               last_nonce <= nonce_in;
               last_valid <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Scoreboard bench for golden_nonce_queue: stimulus commits accepted nonces to
// an expected queue, a negedge monitor checks every word handed to the transmitter.
module tb_golden_nonce_queue;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [31:0]   nonce_in = '0;
   logic          nonce_valid = 1'b0;
   logic          new_work = 1'b0;
   logic          tx_busy;
   logic          tx_send;
   logic [31:0]   tx_word;
   logic [CW-1:0] count;
   logic          empty;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   // reference model: nonces accepted but not yet handed to the transmitter
   logic [31:0] exp_q[$];
   logic [31:0] last_nonce = '0;
   bit          last_valid = 1'b0;
   bit          exp_ovf = 1'b0;

   int sent = 0;
   int busy_mode = 0;   // 0 respond to send, 1 force high, 2 force X, 3 force low
   int busy_len = 4;
   int step_peak = 0;

   always #5 clk = ~clk;

   golden_nonce_queue #(.DEPTH(DEPTH), .DEDUP(1)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .nonce_in    (nonce_in),
      .nonce_valid (nonce_valid),
      .new_work    (new_work),
      .tx_busy     (tx_busy),
      .tx_send     (tx_send),
      .tx_word     (tx_word),
      .count       (count),
      .empty       (empty),
      .overflow    (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // serial_transmit stand-in: busy rises 2 cycles after send is seen
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         case (busy_mode)
            1: tx_busy = 1'b1;
            2: tx_busy = 1'bx;
            3: tx_busy = 1'b0;
            default: begin
               if (tx_send && tx_busy !== 1'b1) begin
                  @(posedge clk);
                  @(posedge clk);
                  #1 tx_busy = 1'b1;
                  repeat (busy_len) @(posedge clk);
                  #1 tx_busy = 1'b0;
               end else begin
                  tx_busy = 1'b0;
               end
            end
         endcase
      end
   end

   // monitor: pops the scoreboard on each new send and checks status outputs
   logic        prev_send = 1'b0;
   logic [31:0] held_word = '0;
   always @(negedge clk) begin
      if (reset_n) begin
         if (tx_send && !prev_send) begin
            sent++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_send actual=%h required=no_send", tx_word);
            end else begin
               check("word_order", tx_word, exp_q.pop_front());
            end
            held_word = tx_word;
            $display("send word=%h queued=%0d", tx_word, count);
         end else if (tx_send && prev_send) begin
            check("word_stable", tx_word, held_word);
         end
         check("count", {28'd0, count}, exp_q.size());
         check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
         check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      end
      prev_send = tx_send;
   end

   // one cycle of stimulus; the model commits it at the closing clock edge
   task automatic step(input bit v, input logic [31:0] n, input bit f);
      nonce_valid = v;
      nonce_in    = n;
      new_work    = f;
      @(negedge clk);
      if (int'(count) > step_peak) step_peak = int'(count);
      @(posedge clk);
      if (f) begin
         exp_q.delete();
         last_valid = 1'b0;
         exp_ovf    = 1'b0;
      end else if (v && !(last_valid && n == last_nonce)) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(n);
            last_nonce = n;
            last_valid = 1'b1;
         end else begin
            exp_ovf = 1'b1;
         end
      end
      #1;
      nonce_valid = 1'b0;
      new_work    = 1'b0;
   endtask

   task automatic drain(input int max);
      int i;
      i = 0;
      while (i < max && (exp_q.size() != 0 || tx_send || tx_busy === 1'b1)) begin
         step(1'b0, '0, 1'b0);
         i++;
      end
      checks++;
      if (i >= max) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      int s0;
      int i;
      bit v;
      bit f;
      logic [31:0] n;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset_send", {31'd0, tx_send}, 32'd0);
      check("reset_word", tx_word, 32'd0);
      check("reset_count", {28'd0, count}, 32'd0);
      check("reset_empty", {31'd0, empty}, 32'd1);
      check("reset_ovf", {31'd0, overflow}, 32'd0);
      reset_n = 1'b1;

      // single nonce: send two cycles after the push, falls after busy seen
      busy_len = 100;
      step(1'b1, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      check("single_send_early", {31'd0, tx_send}, 32'd0);
      @(negedge clk);
      check("single_send_rise", {31'd0, tx_send}, 32'd1);
      check("single_word", tx_word, 32'hDEADBEEF);
      i = 0;
      while (i < 10 && tx_busy !== 1'b1) begin
         @(negedge clk);
         i++;
      end
      check("single_busy_seen", {31'd0, tx_busy}, 32'd1);
      check("single_send_hold", {31'd0, tx_send}, 32'd1);
      @(negedge clk);
      check("single_send_fall", {31'd0, tx_send}, 32'd0);
      @(posedge clk);
      #1;
      drain(200);

      // burst
      busy_len = 6;
      s0 = sent;
      step_peak = 0;
      step(1'b1, 32'h1, 1'b0);
      step(1'b1, 32'h2, 1'b0);
      step(1'b1, 32'h3, 1'b0);
      drain(100);
      check("burst_sent", sent - s0, 32'd3);
      check("burst_peak", step_peak, 32'd2);
      check("burst_empty", {31'd0, empty}, 32'd1);

      // dedup
      s0 = sent;
      step(1'b1, 32'h55, 1'b0);
      step(1'b1, 32'h55, 1'b0);
      step(1'b1, 32'h66, 1'b0);
      step(1'b1, 32'h55, 1'b0);
      drain(100);
      check("dedup_sent", sent - s0, 32'd3);

      // flush while a word is in WAIT with three queued
      busy_len = 40;
      s0 = sent;
      step(1'b1, 32'hA0, 1'b0);
      i = 0;
      while (i < 10 && tx_busy !== 1'b1) begin
         step(1'b0, '0, 1'b0);
         i++;
      end
      step(1'b0, '0, 1'b0);
      step(1'b1, 32'hB1, 1'b0);
      step(1'b1, 32'hB2, 1'b0);
      step(1'b1, 32'hB3, 1'b0);
      @(negedge clk);
      check("flush_pre_count", {28'd0, count}, 32'd3);
      check("flush_in_wait", {31'd0, tx_send}, 32'd0);
      @(posedge clk);
      #1;
      step(1'b1, 32'hC4, 1'b1);
      @(negedge clk);
      check("flush_count", {28'd0, count}, 32'd0);
      @(posedge clk);
      #1;
      drain(100);
      check("flush_sent", sent - s0, 32'd1);
      s0 = sent;
      step(1'b1, 32'hB3, 1'b0);
      drain(100);
      check("flush_dedup_cleared", sent - s0, 32'd1);

      // overflow with busy stuck high
      busy_mode = 1;
      step(1'b0, '0, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b1, 32'h1000 + k, 1'b0);
      @(negedge clk);
      check("ovf_count", {28'd0, count}, 32'd8);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      @(posedge clk);
      #1;
      step(1'b0, '0, 1'b1);
      @(negedge clk);
      check("ovf_cleared", {31'd0, overflow}, 32'd0);
      check("ovf_flushed", {28'd0, count}, 32'd0);
      busy_mode = 0;
      @(posedge clk);
      #1;
      drain(50);

      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         v = ($urandom_range(0, 9) < 4) && (int'(count) < DEPTH - 2);
         f = ($urandom_range(0, 99) < 2);
         n = 32'h100 + $urandom_range(0, 3);
         busy_len = $urandom_range(1, 8);
         step(v, n, f);
      end
      drain(200);

      // asynchronous reset while in SEND with busy unknown
      busy_mode = 3;
      step(1'b0, '0, 1'b0);
      step(1'b1, 32'hABCD0123, 1'b0);
      i = 0;
      while (i < 10 && tx_send !== 1'b1) begin
         @(negedge clk);
         i++;
      end
      check("rst_in_send", {31'd0, tx_send}, 32'd1);
      busy_mode = 2;
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      last_valid = 1'b0;
      exp_ovf = 1'b0;
      #1;
      check("arst_send", {31'd0, tx_send}, 32'd0);
      check("arst_word", tx_word, 32'd0);
      check("arst_count", {28'd0, count}, 32'd0);
      check("arst_empty", {31'd0, empty}, 32'd1);
      check("arst_ovf", {31'd0, overflow}, 32'd0);
      busy_mode = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      s0 = sent;
      repeat (10) step(1'b0, '0, 1'b0);
      check("post_rst_idle", sent - s0, 32'd0);
      check("post_rst_send", {31'd0, tx_send}, 32'd0);
      step(1'b1, 32'h77, 1'b0);
      drain(100);
      check("post_rst_push", sent - s0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
